// File: rtl/reduce_accum_n.sv
// ============================================================================
// Module   : reduce_accum_n
// Function : Joins N P-lane synaptic-current streams, adds the enabled
//            channels lane-wise and accumulates acc_len beats per output.
//            Optional macro REDUCE_ACCUM_SAT_EN selects saturating arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reduce_accum_n #(
    parameter int P    = 64,
    parameter int MWID = 12,
    parameter int N    = 4,
    parameter int LWID = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          ch_en,
    input  logic [LWID-1:0]       acc_len,
    input  logic [N*P*MWID-1:0]   syn_in,
    input  logic [N-1:0]          syn_in_valid,
    output logic [N-1:0]          syn_in_ready,
    output logic [P*MWID-1:0]     syn,
    output logic                  syn_valid,
    input  logic                  syn_ready,
    output logic                  syn_sat
);

`ifdef REDUCE_ACCUM_SAT_EN
    localparam int SWID = MWID + $clog2(N);
`else
    localparam int SWID = MWID;
`endif

    logic [P*MWID-1:0] r_acc;
    logic [LWID-1:0]   r_cnt;
    logic [P*MWID-1:0] r_syn;
    logic              r_syn_valid;

    logic [LWID-1:0]   w_len_eff;
    logic              w_last;
    logic              w_first;
    logic              w_out_free;
    logic              w_wen;
    logic              w_all_ok;
    logic              w_fire;
    logic [P*MWID-1:0] w_next;

    assign w_len_eff  = (acc_len == '0) ? LWID'(1) : acc_len;
    assign w_last     = (r_cnt >= w_len_eff - LWID'(1));
    assign w_first    = (r_cnt == '0);
    assign w_out_free = !r_syn_valid || syn_ready;
    assign w_wen      = !w_last || w_out_free;
    assign w_all_ok   = &(syn_in_valid | ~ch_en);
    assign w_fire     = w_wen && w_all_ok && (|ch_en);

    // A channel's ready depends only on the other enabled channels' valids.
    always_comb begin : p_ready
        logic w_ok;
        syn_in_ready = '0;
        for (int i = 0; i < N; i++) begin
            w_ok = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (k != i) begin
                    w_ok = w_ok & (syn_in_valid[k] | ~ch_en[k]);
                end
            end
            syn_in_ready[i] = w_wen & ch_en[i] & w_ok;
        end
    end

`ifdef REDUCE_ACCUM_SAT_EN
    logic [P-1:0] w_lane_clamp;
`endif

    for (genvar j = 0; j < P; j++) begin : g_lane
        logic [SWID-1:0] w_psum;
        logic [MWID-1:0] w_base;

        always_comb begin
            w_psum = '0;
            for (int i = 0; i < N; i++) begin
                if (ch_en[i]) begin
                    w_psum = w_psum + SWID'(syn_in[(i*P + j)*MWID +: MWID]);
                end
            end
        end

        assign w_base = w_first ? '0 : r_acc[j*MWID +: MWID];

`ifdef REDUCE_ACCUM_SAT_EN
        logic [SWID:0] w_full;
        assign w_full          = (SWID+1)'(w_base) + (SWID+1)'(w_psum);
        assign w_lane_clamp[j] = |w_full[SWID:MWID];
        assign w_next[j*MWID +: MWID] = w_lane_clamp[j] ? '1 : w_full[MWID-1:0];
`else
        assign w_next[j*MWID +: MWID] = w_base + w_psum;
`endif
    end

`ifdef REDUCE_ACCUM_SAT_EN
    logic r_sat_grp;
    logic r_syn_sat;
    logic w_grp_sat;

    // Sticky clamp flag restarts with each group's first fired beat.
    assign w_grp_sat = (w_first ? 1'b0 : r_sat_grp) | (|w_lane_clamp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_grp <= 1'b0;
            r_syn_sat <= 1'b0;
        end else if (w_fire) begin
            if (w_last) begin
                r_syn_sat <= w_grp_sat;
            end else begin
                r_sat_grp <= w_grp_sat;
            end
        end
    end

    assign syn_sat = r_syn_sat;
`else
    assign syn_sat = 1'b0;
`endif

    // A new result loading takes priority over draining the old one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_syn       <= '0;
            r_syn_valid <= 1'b0;
        end else if (w_fire && w_last) begin
            r_syn       <= w_next;
            r_syn_valid <= 1'b1;
            r_cnt       <= '0;
        end else begin
            if (w_fire) begin
                r_acc <= w_next;
                r_cnt <= r_cnt + LWID'(1);
            end
            if (syn_ready) begin
                r_syn_valid <= 1'b0;
            end
        end
    end

    assign syn       = r_syn;
    assign syn_valid = r_syn_valid;

endmodule

`default_nettype wire
